// File: rtl/vending_machine_fsm.sv
// Single-item coin-operated vending controller (Moore FSM, price = 4 credit units).
// Credit is held in the state; a coin seen during a vend cycle starts the next transaction.
module vending_machine_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] money,
    output logic       dispense,
    output logic       change,
    output logic [2:0] current_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        C1       = 3'b001,
        C2       = 3'b010,
        C3       = 3'b011,
        VEND     = 3'b100,
        VEND_CHG = 3'b101
    } state_t;

    localparam logic [2:0] PRICE = 3'd4;

    state_t     state;
    state_t     state_next;
    logic [2:0] base;
    logic [2:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        base       = '0;
        sum        = '0;
        state_next = IDLE;

        case (state)
            IDLE:     base = 3'd0;
            C1:       base = 3'd1;
            C2:       base = 3'd2;
            C3:       base = 3'd3;
            default:  base = 3'd0;
        endcase

        sum = base + {1'b0, money};

        case (state)
            IDLE, C1, C2, C3, VEND, VEND_CHG: begin
                if (sum < PRICE) begin
                    state_next = state_t'(sum);
                end else if (sum == PRICE) begin
                    state_next = VEND;
                end else begin
                    state_next = VEND_CHG;
                end
            end
            // Unused encodings 110/111 recover to IDLE regardless of the coin.
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dispense = (state == VEND) || (state == VEND_CHG);
        change   = (state == VEND_CHG);
    end

    assign current_state = state;

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Directed testbench for vending_machine_fsm: hand-computed state/output
// expectations for exact pay, overpay, carry-over, hold and async reset.
module tb_vending_machine_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] money;
    logic       dispense;
    logic       change;
    logic [2:0] current_state;

    int unsigned checks;
    int unsigned errors;

    vending_machine_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .money         (money),
        .dispense      (dispense),
        .change        (change),
        .current_state (current_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_state(input string tag, input logic [2:0] st,
                                input logic disp, input logic chg);
        check({tag, ".state"},    {5'd0, current_state}, {5'd0, st});
        check({tag, ".dispense"}, {7'd0, dispense},      {7'd0, disp});
        check({tag, ".change"},   {7'd0, change},        {7'd0, chg});
    endtask

    // Present a coin, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [1:0] coin);
        money = coin;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        money  = 2'b00;

        // Reset
        @(posedge clk); @(posedge clk); #1;
        expect_state("in_reset", 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b00);
            expect_state("idle_hold", 3'b000, 1'b0, 1'b0);
        end

        // Exact pay with single units
        step(2'b01); expect_state("exact_c1",   3'b001, 1'b0, 1'b0);
        step(2'b01); expect_state("exact_c2",   3'b010, 1'b0, 1'b0);
        step(2'b01); expect_state("exact_c3",   3'b011, 1'b0, 1'b0);
        step(2'b01); expect_state("exact_vend", 3'b100, 1'b1, 1'b0);
        step(2'b00); expect_state("exact_idle", 3'b000, 1'b0, 1'b0);

        // Overpay then carry-over
        step(2'b10); expect_state("over_c2",    3'b010, 1'b0, 1'b0);
        step(2'b11); expect_state("over_vchg",  3'b101, 1'b1, 1'b1);
        step(2'b11); expect_state("carry_c3",   3'b011, 1'b0, 1'b0);

        // Hold in C3
        for (int i = 0; i < 5; i++) begin
            step(2'b00);
            expect_state("hold_c3", 3'b011, 1'b0, 1'b0);
        end

        // Large coins: C3+3 -> VEND_CHG, then C2+2 -> VEND
        step(2'b11); expect_state("large_vchg", 3'b101, 1'b1, 1'b1);
        step(2'b00); expect_state("vchg_idle",  3'b000, 1'b0, 1'b0);
        step(2'b10); expect_state("large_c2",   3'b010, 1'b0, 1'b0);
        step(2'b10); expect_state("large_vend", 3'b100, 1'b1, 1'b0);
        step(2'b11); expect_state("vend_c3",    3'b011, 1'b0, 1'b0);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        expect_state("async_rst", 3'b000, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        expect_state("async_rel", 3'b000, 1'b0, 1'b0);

        // Accumulate from zero, holding in C1 and C2
        step(2'b01); expect_state("post_c1", 3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b00);
            expect_state("hold_c1", 3'b001, 1'b0, 1'b0);
        end
        step(2'b01); expect_state("post_c2", 3'b010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b00);
            expect_state("hold_c2", 3'b010, 1'b0, 1'b0);
        end

        // Back-to-back vends and vend-state carry-over
        step(2'b11); expect_state("c2p3_vchg", 3'b101, 1'b1, 1'b1);
        step(2'b10); expect_state("vchg_c2",   3'b010, 1'b0, 1'b0);
        step(2'b01); expect_state("c2p1_c3",   3'b011, 1'b0, 1'b0);
        step(2'b01); expect_state("c3p1_vend", 3'b100, 1'b1, 1'b0);
        step(2'b01); expect_state("vend_c1",   3'b001, 1'b0, 1'b0);
        step(2'b11); expect_state("c1p3_vend", 3'b100, 1'b1, 1'b0);
        step(2'b00); expect_state("final_idle",3'b000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
